// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: bundle layouts, access sizes and exception codes.
package mem_stage_pkg;

  localparam int unsigned EX_TO_MEM_W = 107;
  localparam int unsigned MEM_TO_WB_W = 103;
  localparam int unsigned EXCEPT_W    = 87;

  // Memory access size encodings carried in mem_size
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Exception codes as reported to CSR ESTAT.Ecode
  localparam logic [5:0] ECODE_INT = 6'h00;
  localparam logic [5:0] ECODE_ADE = 6'h08;
  localparam logic [5:0] ECODE_ALE = 6'h09;
  localparam logic [5:0] ECODE_SYS = 6'h0b;
  localparam logic [5:0] ECODE_BRK = 6'h0c;
  localparam logic [5:0] ECODE_INE = 6'h0d;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic        gr_we;
    logic [4:0]  rf_waddr;
    logic [31:0] alu_result;
    logic        mem_re;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic        mem_sign;
  } ex_bus_t;

  // exc bits, MSB first: sys, adef, brk, ine, int, ale
  typedef struct packed {
    logic        csr_re;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic [13:0] csr_num;
    logic        ertn_flush;
    logic [5:0]  exc;
  } exc_bus_t;

  // An access was issued to the data SRAM only when no exception suppressed it
  function automatic logic is_mem_req(input ex_bus_t b, input exc_bus_t e);
    return (b.mem_re | b.mem_we) & ~(|e.exc);
  endfunction

  // Highest-priority exception code for a bundle
  function automatic logic [5:0] exc_ecode(input exc_bus_t e);
    if (e.exc[1])      return ECODE_INT;
    else if (e.exc[4]) return ECODE_ADE;
    else if (e.exc[5]) return ECODE_SYS;
    else if (e.exc[3]) return ECODE_BRK;
    else if (e.exc[2]) return ECODE_INE;
    else               return ECODE_ALE;
  endfunction

endpackage

// File: rtl/mem_stage_load_ext.sv
// Load data extractor: selects the addressed byte/half/word and extends it to 32 bits.
module mem_load_ext
  import mem_stage_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] value
);

  logic [31:0] shifted;
  logic [15:0] half;

  assign shifted = raw >> {off, 3'b000};
  assign half    = off[1] ? raw[31:16] : raw[15:0];

  // Pick the lane for the access size and extend
  always_comb begin
    value = raw;
    case (size)
      SZ_B:    value = {{24{sign & shifted[7]}}, shifted[7:0]};
      SZ_H:    value = {{16{sign & half[15]}}, half};
      SZ_W:    value = raw;
      default: value = raw;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds the EX bundle until its data-SRAM response arrives, extracts
// load data, and drops responses that belong to flushed instructions.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned FWD_W = 39
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   EX_to_MEM_valid,
  input  logic [EX_TO_MEM_W-1:0] EX_to_MEM_zip,
  input  logic [EXCEPT_W-1:0]    EX_except_zip,
  output logic                   MEM_allowin,
  input  logic                   data_sram_data_ok,
  input  logic [31:0]            data_sram_rdata,
  input  logic                   WB_allowin,
  input  logic                   wb_flush,
  output logic [MEM_TO_WB_W-1:0] MEM_to_WB_zip,
  output logic [EXCEPT_W-1:0]    MEM_except_zip,
  output logic [FWD_W-1:0]       mem_fwd,
  output logic                   mem_has_ex
);

  ex_bus_t     bus_in, bus_q;
  exc_bus_t    exc_in, exc_q;
  logic        valid_q, wait_q, buf_valid_q;
  logic [31:0] buf_q;
  logic [1:0]  drop_q, drop_d;

  logic        req, req_in, resp_ok, ready_go, leave, accept, capture;
  logic [31:0] raw, load_val, rf_wdata;

  assign bus_in = ex_bus_t'(EX_to_MEM_zip);
  assign exc_in = exc_bus_t'(EX_except_zip);

  assign req     = is_mem_req(bus_q, exc_q);
  assign req_in  = is_mem_req(bus_in, exc_in);
  // Responses seen while drop_q is nonzero belong to flushed instructions
  assign resp_ok = data_sram_data_ok & (drop_q == 2'd0);

  assign ready_go    = ~valid_q | ~req | buf_valid_q | (wait_q & resp_ok);
  assign MEM_allowin = ~valid_q | (ready_go & WB_allowin);
  assign leave       = valid_q & ready_go & WB_allowin;
  assign accept      = EX_to_MEM_valid & MEM_allowin & ~wb_flush;
  assign capture     = resp_ok & valid_q & wait_q & ~WB_allowin & ~wb_flush;

  // Count responses still owed to flushed requests, saturating at 3
  always_comb begin
    logic [2:0] sum;
    sum = {1'b0, drop_q};
    if (wb_flush & valid_q & wait_q & ~resp_ok)                sum = sum + 3'd1;
    if (wb_flush & EX_to_MEM_valid & MEM_allowin & req_in)     sum = sum + 3'd1;
    if (data_sram_data_ok & (drop_q != 2'd0))                  sum = sum - 3'd1;
    drop_d = (sum > 3'd3) ? 2'd3 : sum[1:0];
  end

  // Stage registers: flush beats accept, accept and capture are mutually exclusive
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      wait_q      <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_q       <= '0;
      bus_q       <= '0;
      exc_q       <= '0;
      drop_q      <= 2'd0;
    end else begin
      drop_q <= drop_d;
      if (wb_flush) begin
        valid_q     <= 1'b0;
        wait_q      <= 1'b0;
        buf_valid_q <= 1'b0;
      end else if (accept) begin
        valid_q     <= 1'b1;
        wait_q      <= req_in;
        buf_valid_q <= 1'b0;
        bus_q       <= bus_in;
        exc_q       <= exc_in;
      end else if (leave) begin
        valid_q     <= 1'b0;
        wait_q      <= 1'b0;
        buf_valid_q <= 1'b0;
      end else if (capture) begin
        buf_q       <= data_sram_rdata;
        buf_valid_q <= 1'b1;
        wait_q      <= 1'b0;
      end
    end
  end

  assign raw = buf_valid_q ? buf_q : data_sram_rdata;

  mem_load_ext u_load_ext (
    .raw   (raw),
    .off   (bus_q.alu_result[1:0]),
    .size  (bus_q.mem_size),
    .sign  (bus_q.mem_sign),
    .value (load_val)
  );

  assign rf_wdata = bus_q.mem_re ? load_val : bus_q.alu_result;

  assign MEM_to_WB_zip  = {valid_q & ready_go, bus_q.pc, bus_q.ir, bus_q.gr_we, bus_q.rf_waddr,
                           rf_wdata};
  assign MEM_except_zip = exc_q;
  assign mem_fwd        = FWD_W'({valid_q & bus_q.gr_we, bus_q.rf_waddr, rf_wdata,
                                  valid_q & bus_q.mem_re & ~ready_go});
  assign mem_has_ex     = valid_q & (exc_q.ertn_flush | (|exc_q.exc));

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic         EX_to_MEM_valid;
  logic [106:0] EX_to_MEM_zip;
  logic [86:0]  EX_except_zip;
  logic         MEM_allowin;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic         WB_allowin;
  logic         wb_flush;
  logic [102:0] MEM_to_WB_zip;
  logic [86:0]  MEM_except_zip;
  logic [38:0]  mem_fwd;
  logic         mem_has_ex;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_stage #(.FWD_W(39)) dut (
    .clk               (clk),
    .rst               (rst),
    .EX_to_MEM_valid   (EX_to_MEM_valid),
    .EX_to_MEM_zip     (EX_to_MEM_zip),
    .EX_except_zip     (EX_except_zip),
    .MEM_allowin       (MEM_allowin),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .WB_allowin        (WB_allowin),
    .wb_flush          (wb_flush),
    .MEM_to_WB_zip     (MEM_to_WB_zip),
    .MEM_except_zip    (MEM_except_zip),
    .mem_fwd           (mem_fwd),
    .mem_has_ex        (mem_has_ex)
  );

  wire        wb_valid = MEM_to_WB_zip[102];
  wire [31:0] wb_wdata = MEM_to_WB_zip[31:0];
  wire        fwd_v    = mem_fwd[38];
  wire [4:0]  fwd_addr = mem_fwd[37:33];
  wire [31:0] fwd_data = mem_fwd[32:1];
  wire        fwd_lp   = mem_fwd[0];

  function automatic logic [106:0] mk_ex(input logic [31:0] pc, input logic gr_we,
                                         input logic [4:0] waddr, input logic [31:0] alu,
                                         input logic re, input logic we,
                                         input logic [1:0] size, input logic sign);
    return {pc, {pc[15:0], 16'h1234}, gr_we, waddr, alu, re, we, size, sign};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; EX_to_MEM_valid = 1'b0; EX_to_MEM_zip = '0; EX_except_zip = '0;
    data_sram_data_ok = 1'b0; data_sram_rdata = '0; WB_allowin = 1'b1; wb_flush = 1'b0;
    step(); step();
    rst = 1'b0;
    settle();
    if (MEM_to_WB_zip !== 103'd0) begin n_fail++; $display("FAIL reset_wb_zip: got %h expected 0", MEM_to_WB_zip); end
    n_checks++;
    if (MEM_except_zip !== 87'd0) begin n_fail++; $display("FAIL reset_exc_zip: got %h expected 0", MEM_except_zip); end
    n_checks++;
    if (mem_fwd !== 39'd0) begin n_fail++; $display("FAIL reset_fwd: got %h expected 0", mem_fwd); end
    n_checks++;
    if (MEM_allowin !== 1'b1) begin n_fail++; $display("FAIL reset_allowin: got %b expected 1", MEM_allowin); end
    n_checks++;
  endtask

  task automatic test_ld_b();
    EX_to_MEM_zip = mk_ex(32'h1c00_0100, 1'b1, 5'd4, 32'h0000_1003, 1'b1, 1'b0, 2'd0, 1'b1);
    EX_to_MEM_valid = 1'b1;
    step();
    EX_to_MEM_valid = 1'b0;
    settle();
    if (MEM_allowin !== 1'b0) begin n_fail++; $display("FAIL ldb_allowin_wait1: got %b expected 0", MEM_allowin); end
    n_checks++;
    if (fwd_lp !== 1'b1) begin n_fail++; $display("FAIL ldb_load_pending: got %b expected 1", fwd_lp); end
    n_checks++;
    step();
    if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL ldb_wb_valid_wait: got %b expected 0", wb_valid); end
    n_checks++;
    if (MEM_allowin !== 1'b0) begin n_fail++; $display("FAIL ldb_allowin_wait2: got %b expected 0", MEM_allowin); end
    n_checks++;
    step();
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80FF_1234;
    settle();
    if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL ldb_wb_valid: got %b expected 1", wb_valid); end
    n_checks++;
    if (wb_wdata !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL ldb_wdata: got %h expected ffffff80", wb_wdata); end
    n_checks++;
    if (MEM_allowin !== 1'b1) begin n_fail++; $display("FAIL ldb_allowin_done: got %b expected 1", MEM_allowin); end
    n_checks++;
    step();
    data_sram_data_ok = 1'b0;
    settle();
    if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL ldb_single_wb: got %b expected 0", wb_valid); end
    n_checks++;
  endtask

  task automatic test_ld_hu_buffered();
    EX_to_MEM_zip = mk_ex(32'h1c00_0200, 1'b1, 5'd5, 32'h0000_2002, 1'b1, 1'b0, 2'd1, 1'b0);
    EX_to_MEM_valid = 1'b1;
    step();
    EX_to_MEM_valid = 1'b0; WB_allowin = 1'b0;
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hBEEF_0000;
    settle();
    if (MEM_allowin !== 1'b0) begin n_fail++; $display("FAIL ldhu_allowin_stall: got %b expected 0", MEM_allowin); end
    n_checks++;
    step();
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'h1234_5678;
    settle();
    if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL ldhu_wb_valid_buf: got %b expected 1", wb_valid); end
    n_checks++;
    if (wb_wdata !== 32'h0000_BEEF) begin n_fail++; $display("FAIL ldhu_wdata_buf: got %h expected 0000beef", wb_wdata); end
    n_checks++;
    if (fwd_lp !== 1'b0) begin n_fail++; $display("FAIL ldhu_load_pending: got %b expected 0", fwd_lp); end
    n_checks++;
    WB_allowin = 1'b1;
    settle();
    if (MEM_allowin !== 1'b1) begin n_fail++; $display("FAIL ldhu_allowin_release: got %b expected 1", MEM_allowin); end
    n_checks++;
    step();
    if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL ldhu_left: got %b expected 0", wb_valid); end
    n_checks++;
  endtask

  task automatic test_extract();
    logic [31:0] alu_t [5] = '{32'h3000, 32'h3001, 32'h3004, 32'h3008, 32'h300A};
    logic [1:0]  size_t[5] = '{2'd1, 2'd0, 2'd2, 2'd0, 2'd1};
    logic        sign_t[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] data_t[5] = '{32'h1234_8765, 32'h0000_A500, 32'hCAFE_F00D, 32'h0000_007F,
                               32'h7FFF_0000};
    logic [31:0] exp_t [5] = '{32'hFFFF_8765, 32'h0000_00A5, 32'hCAFE_F00D, 32'h0000_007F,
                               32'h0000_7FFF};
    for (int i = 0; i < 5; i++) begin
      EX_to_MEM_zip = mk_ex(32'h1c00_0300, 1'b1, 5'd6, alu_t[i], 1'b1, 1'b0, size_t[i], sign_t[i]);
      EX_to_MEM_valid = 1'b1;
      step();
      EX_to_MEM_valid = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = data_t[i];
      settle();
      if (wb_wdata !== exp_t[i]) begin n_fail++; $display("FAIL extract_%0d: got %h expected %h", i, wb_wdata, exp_t[i]); end
      n_checks++;
      step();
      data_sram_data_ok = 1'b0;
    end
  endtask

  task automatic test_store();
    EX_to_MEM_zip = mk_ex(32'h1c00_0400, 1'b0, 5'd0, 32'h0000_4000, 1'b0, 1'b1, 2'd2, 1'b0);
    EX_to_MEM_valid = 1'b1;
    step();
    EX_to_MEM_valid = 1'b0;
    settle();
    if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL st_wait: got %b expected 0", wb_valid); end
    n_checks++;
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hFFFF_FFFF;
    settle();
    if (wb_valid !== 1'b1 || wb_wdata !== 32'h0000_4000 || fwd_v !== 1'b0) begin
      n_fail++; $display("FAIL st_done: got v=%b d=%h fv=%b expected v=1 d=00004000 fv=0", wb_valid, wb_wdata, fwd_v);
    end
    n_checks++;
    step();
    data_sram_data_ok = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      EX_to_MEM_zip = mk_ex(32'h1c00_0500 + 32'(4 * i), 1'b1, 5'(i + 1), 32'h100 + 32'(i),
                            1'b0, 1'b0, 2'd2, 1'b0);
      EX_to_MEM_valid = 1'b1;
      settle();
      if (MEM_allowin !== 1'b1) begin n_fail++; $display("FAIL b2b_allowin_%0d: got %b expected 1", i, MEM_allowin); end
      n_checks++;
      step();
      if (wb_valid !== 1'b1 || wb_wdata !== 32'h100 + 32'(i)) begin
        n_fail++; $display("FAIL b2b_wb_%0d: got v=%b d=%h expected v=1 d=%h", i, wb_valid, wb_wdata, 32'h100 + 32'(i));
      end
      n_checks++;
      if (fwd_v !== 1'b1 || fwd_addr !== 5'(i + 1) || fwd_data !== 32'h100 + 32'(i) || fwd_lp !== 1'b0) begin
        n_fail++; $display("FAIL b2b_fwd_%0d: got %h", i, mem_fwd);
      end
      n_checks++;
    end
    EX_to_MEM_valid = 1'b0;
    step();
    if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b expected 0", wb_valid); end
    n_checks++;
  endtask

  task automatic test_flush();
    EX_to_MEM_zip = mk_ex(32'h1c00_0600, 1'b1, 5'd7, 32'h0000_5000, 1'b1, 1'b0, 2'd2, 1'b0);
    EX_to_MEM_valid = 1'b1;
    step();
    EX_to_MEM_valid = 1'b0; wb_flush = 1'b1;
    step();
    wb_flush = 1'b0;
    settle();
    if (wb_valid !== 1'b0 || MEM_allowin !== 1'b1 || fwd_v !== 1'b0) begin
      n_fail++; $display("FAIL flush_clear: got v=%b allowin=%b fv=%b expected 0 1 0", wb_valid, MEM_allowin, fwd_v);
    end
    n_checks++;
    EX_to_MEM_zip = mk_ex(32'h1c00_0604, 1'b1, 5'd8, 32'h0000_5004, 1'b1, 1'b0, 2'd2, 1'b0);
    EX_to_MEM_valid = 1'b1;
    step();
    EX_to_MEM_valid = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF;
    settle();
    if (wb_valid !== 1'b0 || MEM_allowin !== 1'b0) begin
      n_fail++; $display("FAIL flush_stale_ignored: got v=%b allowin=%b expected 0 0", wb_valid, MEM_allowin);
    end
    n_checks++;
    step();
    data_sram_rdata = 32'h1122_3344;
    settle();
    if (wb_valid !== 1'b1 || wb_wdata !== 32'h1122_3344) begin
      n_fail++; $display("FAIL flush_next_load: got v=%b d=%h expected v=1 d=11223344", wb_valid, wb_wdata);
    end
    n_checks++;
    step();
    data_sram_data_ok = 1'b0;
    // Flush while empty must also block acceptance of a handed-over instruction
    EX_to_MEM_zip = mk_ex(32'h1c00_0608, 1'b1, 5'd9, 32'h0000_0009, 1'b0, 1'b0, 2'd2, 1'b0);
    EX_to_MEM_valid = 1'b1; wb_flush = 1'b1;
    step();
    EX_to_MEM_valid = 1'b0; wb_flush = 1'b0;
    settle();
    if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL flush_blocks_accept: got %b expected 0", wb_valid); end
    n_checks++;
  endtask

  task automatic test_except();
    logic [86:0] exc;
    exc = {1'b1, 1'b0, 32'hFFFF_0000, 32'h1234_5678, 14'h0006, 1'b0, 6'b000001};
    EX_to_MEM_zip = mk_ex(32'h1c00_0700, 1'b1, 5'd10, 32'h0000_6001, 1'b1, 1'b0, 2'd2, 1'b0);
    EX_except_zip = exc;
    EX_to_MEM_valid = 1'b1;
    step();
    EX_to_MEM_valid = 1'b0; EX_except_zip = '0;
    settle();
    if (wb_valid !== 1'b1 || MEM_allowin !== 1'b1 || fwd_lp !== 1'b0) begin
      n_fail++; $display("FAIL ale_pass: got v=%b allowin=%b lp=%b expected 1 1 0", wb_valid, MEM_allowin, fwd_lp);
    end
    n_checks++;
    if (mem_has_ex !== 1'b1) begin n_fail++; $display("FAIL ale_has_ex: got %b expected 1", mem_has_ex); end
    n_checks++;
    if (MEM_except_zip !== exc) begin n_fail++; $display("FAIL ale_exc_zip: got %h expected %h", MEM_except_zip, exc); end
    n_checks++;
    step();
    if (mem_has_ex !== 1'b0) begin n_fail++; $display("FAIL ale_has_ex_clear: got %b expected 0", mem_has_ex); end
    n_checks++;
  endtask

  task automatic test_reset_mid_wait();
    EX_to_MEM_zip = mk_ex(32'h1c00_0800, 1'b1, 5'd11, 32'h0000_7000, 1'b1, 1'b0, 2'd2, 1'b0);
    EX_to_MEM_valid = 1'b1;
    step();
    EX_to_MEM_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    settle();
    if (MEM_to_WB_zip !== 103'd0 || mem_fwd !== 39'd0 || MEM_except_zip !== 87'd0) begin
      n_fail++; $display("FAIL rst_mid_outputs: got wb=%h fwd=%h expected 0", MEM_to_WB_zip, mem_fwd);
    end
    n_checks++;
    if (MEM_allowin !== 1'b1) begin n_fail++; $display("FAIL rst_mid_allowin: got %b expected 1", MEM_allowin); end
    n_checks++;
    EX_to_MEM_zip = mk_ex(32'h1c00_0804, 1'b1, 5'd12, 32'h0000_7004, 1'b1, 1'b0, 2'd2, 1'b0);
    EX_to_MEM_valid = 1'b1;
    step();
    EX_to_MEM_valid = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0BAD_F00D;
    settle();
    if (wb_valid !== 1'b1 || wb_wdata !== 32'h0BAD_F00D) begin
      n_fail++; $display("FAIL rst_mid_no_drop: got v=%b d=%h expected v=1 d=0badf00d", wb_valid, wb_wdata);
    end
    n_checks++;
    step();
    data_sram_data_ok = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ld_b();
    test_ld_hu_buffered();
    test_extract();
    test_store();
    test_back_to_back();
    test_flush();
    test_except();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
